// File: rtl/adat_frame_decoder_pkg.sv
// adat_frame_decoder_pkg: shared ADAT frame constants and decoder state encoding
package adat_frame_decoder_pkg;
  localparam int ADAT_SYNC_ZEROS = 10;
  localparam int ADAT_NUM_CH = 8;
  localparam int ADAT_NIB_PER_CH = 6;
  localparam int ADAT_SAMPLE_W = 24;
  typedef enum logic [1:0] {HUNT = 2'd0, USER = 2'd1, CHAN = 2'd2, SYNC = 2'd3} state_t;
endpackage

// File: rtl/adat_sync_detect.sv
// adat_sync_detect: saturating zero-run counter and sync length flags
module adat_sync_detect
  import adat_frame_decoder_pkg::*;
(
  input  logic refclk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_valid,
  output logic sync_ok,
  output logic sync_short,
  output logic sync_long
);
  localparam logic [3:0] SYNC_N = 4'(ADAT_SYNC_ZEROS);
  logic [3:0] zero_run_q, zero_run_d;
  // count zeros since the last one, saturating at 15
  always_comb zero_run_d = !bit_valid ? zero_run_q : bit_in ? 4'd0 : zero_run_q == 4'hf ? zero_run_q : zero_run_q + 4'd1;
  // zero-run register
  always_ff @(posedge refclk or negedge reset_n)
    if (!reset_n) zero_run_q <= 4'd0;
    else zero_run_q <= zero_run_d;
  assign sync_ok = zero_run_q == SYNC_N;
  assign sync_short = zero_run_q < SYNC_N;
  assign sync_long = zero_run_q >= SYNC_N;
endmodule

// File: rtl/adat_frame_decoder.sv
// adat_frame_decoder: ADAT frame sync, marker checking and channel de-serialisation
module adat_frame_decoder
  import adat_frame_decoder_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic                     refclk,
  input  logic                     reset_n,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [ADAT_SAMPLE_W-1:0] ch_data,
  output logic [2:0]               ch_idx,
  output logic                     ch_valid,
  output logic [3:0]               user_bits,
  output logic                     frame_start,
  output logic                     locked,
  output logic                     frame_err
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [2:0] LAST_NIB = 3'(ADAT_NIB_PER_CH - 1);
  localparam logic [2:0] LAST_CH = 3'(ADAT_NUM_CH - 1);
  state_t state_q, state_d;
  logic [2:0] ch_q, ch_d, nib_q, nib_d, ch_idx_q, ch_idx_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic mark_q, mark_d, err;
  logic [ADAT_SAMPLE_W-1:0] sh_q, sh_d, ch_data_q, ch_data_d;
  logic [3:0] good_q, good_d, good_inc, user_q, user_d;
  logic ch_valid_q, ch_valid_d, frame_start_q, frame_start_d;
  logic locked_q, locked_d, frame_err_q, frame_err_d;
  logic sync_ok, sync_short, sync_long;
  adat_sync_detect u_sync (
    .refclk     (refclk),
    .reset_n    (reset_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sync_ok    (sync_ok),
    .sync_short (sync_short),
    .sync_long  (sync_long)
  );
  assign good_inc = good_q == 4'hf ? good_q : good_q + 4'd1;
  // frame state machine: every decision is taken on a bit strobe
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    nib_d = nib_q;
    bcnt_d = bcnt_q;
    mark_d = mark_q;
    sh_d = sh_q;
    good_d = good_q;
    user_d = user_q;
    ch_data_d = ch_data_q;
    ch_idx_d = ch_idx_q;
    locked_d = locked_q;
    ch_valid_d = 1'b0;
    frame_start_d = 1'b0;
    frame_err_d = 1'b0;
    err = 1'b0;
    if (bit_valid)
      case (state_q)
        HUNT: if (bit_in && !sync_short) begin
          frame_start_d = 1'b1;
          state_d = USER;
          bcnt_d = 2'd0;
          mark_d = 1'b0;
        end
        USER: if (!mark_q) begin
          sh_d = {sh_q[ADAT_SAMPLE_W-2:0], bit_in};
          bcnt_d = bcnt_q + 2'd1;
          mark_d = bcnt_q == 2'd3;
        end else if (!bit_in) err = 1'b1;
        else begin
          user_d = sh_q[3:0];
          state_d = CHAN;
          ch_d = 3'd0;
          nib_d = 3'd0;
          mark_d = 1'b0;
        end
        CHAN: if (!mark_q) begin
          sh_d = {sh_q[ADAT_SAMPLE_W-2:0], bit_in};
          bcnt_d = bcnt_q + 2'd1;
          mark_d = bcnt_q == 2'd3;
        end else if (!bit_in) err = 1'b1;
        else begin
          mark_d = 1'b0;
          nib_d = nib_q == LAST_NIB ? 3'd0 : nib_q + 3'd1;
          if (nib_q == LAST_NIB) begin
            ch_data_d = sh_q;
            ch_idx_d = ch_q;
            ch_valid_d = 1'b1;
            ch_d = ch_q == LAST_CH ? ch_q : ch_q + 3'd1;
            if (ch_q == LAST_CH) begin
              state_d = SYNC;
              good_d = good_inc;
              locked_d = locked_q | (good_inc >= LOCK_N);
            end
          end
        end
        SYNC: if (bit_in) begin
          err = !sync_ok;
          frame_start_d = sync_ok;
          state_d = sync_ok ? USER : SYNC;
          bcnt_d = 2'd0;
          mark_d = 1'b0;
        end else err = sync_long;
      endcase
    if (err) begin
      frame_err_d = 1'b1;
      state_d = HUNT;
      good_d = 4'd0;
      locked_d = 1'b0;
      mark_d = 1'b0;
      bcnt_d = 2'd0;
    end
  end
  // state and registered outputs
  always_ff @(posedge refclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= HUNT;
      ch_q <= 3'd0;
      nib_q <= 3'd0;
      bcnt_q <= 2'd0;
      mark_q <= 1'b0;
      sh_q <= '0;
      good_q <= 4'd0;
      user_q <= 4'd0;
      ch_data_q <= '0;
      ch_idx_q <= 3'd0;
      locked_q <= 1'b0;
      ch_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      nib_q <= nib_d;
      bcnt_q <= bcnt_d;
      mark_q <= mark_d;
      sh_q <= sh_d;
      good_q <= good_d;
      user_q <= user_d;
      ch_data_q <= ch_data_d;
      ch_idx_q <= ch_idx_d;
      locked_q <= locked_d;
      ch_valid_q <= ch_valid_d;
      frame_start_q <= frame_start_d;
      frame_err_q <= frame_err_d;
    end
  assign ch_data = ch_data_q;
  assign ch_idx = ch_idx_q;
  assign ch_valid = ch_valid_q;
  assign user_bits = user_q;
  assign frame_start = frame_start_q;
  assign locked = locked_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_adat_frame_decoder.sv
// tb_adat_frame_decoder: scoreboard bench for the ADAT frame decoder
module tb_adat_frame_decoder;
  localparam int LOCK = 2;
  localparam logic [35:0] EV_FS = 36'h2_0000_0000;
  localparam logic [35:0] EV_ERR = 36'h3_0000_0000;
  logic refclk = 1'b0, reset_n = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic [23:0] ch_data;
  logic [2:0] ch_idx;
  logic [3:0] user_bits;
  logic ch_valid, frame_start, locked, frame_err;
  int n_pass = 0, n_chk = 0, gc = 0;
  bit jit = 1'b0, ign = 1'b0, lk = 1'b0;
  logic [35:0] sb[$];
  logic [35:0] eq[$];
  bit bq[$];
  adat_frame_decoder #(.LOCK_FRAMES(LOCK)) dut (
    .refclk      (refclk),
    .reset_n     (reset_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .ch_data     (ch_data),
    .ch_idx      (ch_idx),
    .ch_valid    (ch_valid),
    .user_bits   (user_bits),
    .frame_start (frame_start),
    .locked      (locked),
    .frame_err   (frame_err)
  );
  always #5 refclk = ~refclk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic mon(string tag, logic [35:0] o);
    if (sb.size() == 0) check({tag, "_unexpected"}, {28'h0, o}, 64'h0);
    else check(tag, {28'h0, o}, {28'h0, sb.pop_front()});
  endtask
  // output events compared against the expected queue
  always @(negedge refclk)
    if (!ign && reset_n) begin
      if (frame_err) mon("err", {4'h3, 4'h0, locked, 3'h0, 24'h0});
      if (frame_start) mon("fs", EV_FS);
      if (ch_valid) mon("ch", {4'h1, user_bits, locked, ch_idx, ch_data});
    end
  task automatic send_bit(bit b);
    int g;
    g = jit ? int'($urandom_range(9, 7)) : 8;
    @(posedge refclk);
    #1 bit_in = b;
    bit_valid = 1'b1;
    @(posedge refclk);
    #1 bit_valid = 1'b0;
    repeat (g - 2) @(posedge refclk);
  endtask
  task automatic add(bit b, logic [35:0] e);
    bq.push_back(b);
    eq.push_back(e);
  endtask
  task automatic drive(int n);
    logic [35:0] e;
    bit b;
    while (bq.size() > 0 && n != 0) begin
      e = eq.pop_front();
      b = bq.pop_front();
      if (e != 36'h0) sb.push_back(e);
      send_bit(b);
      n--;
    end
  endtask
  task automatic zeros(int n);
    repeat (n) add(1'b0, 36'h0);
  endtask
  task automatic body(logic [3:0] u, logic [23:0] base, int bad_ch, int bad_nib, bit quiet);
    logic [23:0] d;
    for (int i = 3; i >= 0; i--) add(u[i], 36'h0);
    add(1'b1, 36'h0);
    for (int c = 0; c < 8; c++) begin
      d = base + 24'(c);
      for (int n = 0; n < 6; n++) begin
        for (int k = 0; k < 4; k++) add(d[23-4*n-k], 36'h0);
        if (c == bad_ch && n == bad_nib) begin
          gc = 0;
          lk = 1'b0;
          add(1'b0, EV_ERR);
          return;
        end
        if (n < 5 || quiet) add(1'b1, 36'h0);
        else begin
          if (c == 7) begin
            gc = gc < 15 ? gc + 1 : 15;
            if (gc >= LOCK) lk = 1'b1;
          end
          add(1'b1, {4'h1, u, lk, 3'(c), d});
        end
      end
    end
  endtask
  task automatic frame(logic [3:0] u, logic [23:0] base);
    zeros(10);
    add(1'b1, EV_FS);
    body(u, base, -1, -1, 1'b0);
    drive(-1);
  endtask
  task automatic chk_rst(string t);
    check({t, "_data"}, {40'h0, ch_data}, 64'h0);
    check({t, "_idx"}, {61'h0, ch_idx}, 64'h0);
    check({t, "_valid"}, {63'h0, ch_valid}, 64'h0);
    check({t, "_user"}, {60'h0, user_bits}, 64'h0);
    check({t, "_fs"}, {63'h0, frame_start}, 64'h0);
    check({t, "_lock"}, {63'h0, locked}, 64'h0);
    check({t, "_err"}, {63'h0, frame_err}, 64'h0);
  endtask
  initial begin
    repeat (3) @(posedge refclk);
    #1 chk_rst("rst_init");
    #2 reset_n = 1'b1;
    @(negedge refclk);
    chk_rst("rst_idle");
    repeat (3) frame(4'h9, 24'hA50000);
    check("lock_clean", {63'h0, locked}, {63'h0, lk});
    zeros(10);
    add(1'b1, EV_FS);
    body(4'h9, 24'hA50000, 3, 2, 1'b0);
    drive(-1);
    check("lock_after_err", {63'h0, locked}, 64'h0);
    frame(4'h9, 24'hA50000);
    check("lock_one_frame", {63'h0, locked}, 64'h0);
    frame(4'h9, 24'hA50000);
    check("lock_two_frames", {63'h0, locked}, 64'h1);
    zeros(9);
    gc = 0;
    lk = 1'b0;
    add(1'b1, EV_ERR);
    drive(-1);
    frame(4'h3, 24'h5A0F00);
    zeros(10);
    gc = 0;
    lk = 1'b0;
    add(1'b0, EV_ERR);
    add(1'b1, EV_FS);
    body(4'hE, 24'h13579B, -1, -1, 1'b0);
    drive(-1);
    frame(4'h2, 24'hFEDCB0);
    jit = 1'b0;
    frame(4'h7, 24'h0F0F00);
    frame(4'h5, 24'hC3C3C0);
    jit = 1'b1;
    frame(4'h7, 24'h0F0F00);
    frame(4'h5, 24'hC3C3C0);
    jit = 1'b0;
    check("pre_rst_lock", {63'h0, locked}, 64'h1);
    zeros(10);
    add(1'b1, EV_FS);
    body(4'h6, 24'hA50000, -1, -1, 1'b0);
    drive(110);
    @(posedge refclk);
    #3 reset_n = 1'b0;
    #1 chk_rst("rst_mid");
    bq.delete();
    eq.delete();
    gc = 0;
    lk = 1'b0;
    repeat (3) @(posedge refclk);
    #3 reset_n = 1'b1;
    body(4'h9, 24'hA50000, -1, -1, 1'b1);
    drive(-1);
    frame(4'hC, 24'h123450);
    ign = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      send_bit(1'($urandom));
      check("rand_lock", {63'h0, locked}, 64'h0);
    end
    repeat (40) send_bit(1'b0);
    repeat (4) @(posedge refclk);
    ign = 1'b0;
    gc = 0;
    lk = 1'b0;
    for (int f = 0; f < 3; f++) frame(4'(f), 24'($urandom));
    check("lock_after_rand", {63'h0, locked}, 64'h1);
    repeat (20) @(posedge refclk);
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
